cordic_rotation_scheduler: RTL and testbench

//  - Shares the single CORDIC sprite-rotation engine between NREQ sprite requesters (ants), round-robin.
//  - Per job: latches the requester's angle, pulses the engine reset, waits for engine done,

---
 rtl/cordic_rotation_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_cordic_rotation_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rotation_scheduler.sv
// cordic_rotation_scheduler
//   Shares one CORDIC sprite-rotation engine between NREQ requesters, round-robin.
//   Per job: latch the winner's angle, pulse the engine reset, wait for cord_done,
//   stream row indices and write the rotated rows into the sprite row buffers.
//
// Optional feature macro: SCHED_TIMEOUT_EN
//   When defined, WAIT is bounded by TMO cycles; expiry aborts the job with an err pulse.
//   When undefined, WAIT is unbounded and err only reports a mid-stream cord_done drop.
//
// Ports
//   logicCLK    in   system clock, all state on posedge
//   KEY0_N      in   asynchronous active-low reset
//   req         in   level requests, one bit per requester
//   angle_in    in   packed angles, requester i at [i*ANGLE_W +: ANGLE_W]
//   ack         out  one-cycle pulse on the served requester's bit at job completion
//   busy        out  high from grant until DONE exits
//   cord_rst    out  one-cycle engine start pulse
//   cord_angle  out  angle latched at grant
//   cord_idx    out  row index presented to the engine
//   cord_data   in   rotated row, LAT cycles behind cord_idx
//   cord_done   in   engine result valid, must stay high while streaming
//   wr_en       out  sprite-buffer write strobe
//   wr_sel      out  destination requester id
//   wr_row      out  destination row
//   wr_data     out  registered copy of cord_data
//   err         out  one-cycle pulse on an aborted job
module cordic_rotation_scheduler #(
  parameter int NREQ    = 2,
  parameter int ROWS    = 57,
  parameter int ROW_W   = 57,
  parameter int ANGLE_W = 13,
  parameter int IDX_W   = 10,
  parameter int LAT     = 2
`ifdef SCHED_TIMEOUT_EN
  , parameter int TMO   = 4095
`endif
) (
  input  logic                    logicCLK,
  input  logic                    KEY0_N,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*ANGLE_W-1:0] angle_in,
  output logic [NREQ-1:0]         ack,
  output logic                    busy,
  output logic                    cord_rst,
  output logic [ANGLE_W-1:0]      cord_angle,
  output logic [IDX_W-1:0]        cord_idx,
  input  logic [ROW_W-1:0]        cord_data,
  input  logic                    cord_done,
  output logic                    wr_en,
  output logic [2:0]              wr_sel,
  output logic [5:0]              wr_row,
  output logic [ROW_W-1:0]        wr_data,
  output logic                    err
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_STREAM, S_DONE} state_t;

  localparam logic [IDX_W-1:0] K_LAT  = IDX_W'(LAT);
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(ROWS + LAT - 1);
  localparam logic [2:0]       G_LAST = 3'(NREQ - 1);

  state_t               r_state;
  logic [2:0]           r_ptr;
  logic [2:0]           r_g;
  logic [IDX_W-1:0]     r_k;
  logic [NREQ-1:0]      r_ack;
  logic                 r_busy;
  logic                 r_cord_rst;
  logic [ANGLE_W-1:0]   r_angle;
  logic                 r_wr_en;
  logic [2:0]           r_wr_sel;
  logic [5:0]           r_wr_row;
  logic [ROW_W-1:0]     r_wr_data;
  logic                 r_err;
`ifdef SCHED_TIMEOUT_EN
  logic [11:0]          r_tmo;
`endif

  // Round-robin search: rotate the doubled request vector so bit 0 is the
  // requester at ptr, take the lowest set bit, then map the offset back.
  logic [2*NREQ-1:0]    w_req2;
  logic [NREQ-1:0]      w_rot;
  logic                 w_found;
  logic [2:0]           w_off;
  logic [3:0]           w_sum;
  logic [2:0]           w_gnt;
  logic [ANGLE_W-1:0]   w_angles [NREQ];
  logic [ANGLE_W-1:0]   w_angle;
  logic [NREQ-1:0]      w_g_onehot;

  assign w_req2 = {req, req};
  assign w_rot  = w_req2[r_ptr +: NREQ];

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_found = 1'b1;
        w_off   = 3'(i);
      end
    end
  end

  assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_gnt = (w_sum >= 4'(NREQ)) ? 3'(w_sum - 4'(NREQ)) : w_sum[2:0];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign w_angles[gi]   = angle_in[gi*ANGLE_W +: ANGLE_W];
    assign w_g_onehot[gi] = (r_g == 3'(gi));
  end

  always_comb begin
    w_angle = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt == 3'(i)) w_angle = w_angles[i];
    end
  end

  always_ff @(posedge logicCLK or negedge KEY0_N) begin
    if (!KEY0_N) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_g        <= '0;
      r_k        <= '0;
      r_ack      <= '0;
      r_busy     <= 1'b0;
      r_cord_rst <= 1'b0;
      r_angle    <= '0;
      r_wr_en    <= 1'b0;
      r_wr_sel   <= '0;
      r_wr_row   <= '0;
      r_wr_data  <= '0;
      r_err      <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      r_tmo      <= '0;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      r_cord_rst <= 1'b0;
      r_ack      <= '0;
      r_err      <= 1'b0;
      r_wr_en    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_g        <= w_gnt;
            r_angle    <= w_angle;
            r_busy     <= 1'b1;
            r_cord_rst <= 1'b1;
            r_k        <= '0;
            r_state    <= S_START;
          end
        end
        S_START: begin
`ifdef SCHED_TIMEOUT_EN
          r_tmo   <= '0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (cord_done) begin
            r_k     <= '0;
            r_state <= S_STREAM;
`ifdef SCHED_TIMEOUT_EN
            r_tmo   <= '0;
          end else if (r_tmo == 12'(TMO - 1)) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_tmo   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tmo   <= r_tmo + 12'd1;
`endif
          end
        end
        S_STREAM: begin
          if (!cord_done) begin
            // Engine lost its result: drop the job, ptr untouched so it is retried.
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_k     <= '0;
            r_state <= S_IDLE;
          end else begin
            // cord_data now belongs to index k-LAT.
            if (r_k >= K_LAT) begin
              r_wr_en   <= 1'b1;
              r_wr_sel  <= r_g;
              r_wr_row  <= 6'(r_k - K_LAT);
              r_wr_data <= cord_data;
            end
            if (r_k == K_LAST) begin
              r_k     <= '0;
              r_ack   <= w_g_onehot;
              r_state <= S_DONE;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_ptr   <= (r_g == G_LAST) ? 3'd0 : r_g + 3'd1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack        = r_ack;
  assign busy       = r_busy;
  assign cord_rst   = r_cord_rst;
  assign cord_angle = r_angle;
  assign cord_idx   = r_k;
  assign wr_en      = r_wr_en;
  assign wr_sel     = r_wr_sel;
  assign wr_row     = r_wr_row;
  assign wr_data    = r_wr_data;
  assign err        = r_err;

endmodule

// File: tb/tb_cordic_rotation_scheduler.sv
module tb_cordic_rotation_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0;
  logic [25:0] angle_in = '0;
  logic [1:0]  ack;
  logic        busy;
  logic        cord_rst;
  logic [12:0] cord_angle;
  logic [9:0]  cord_idx;
  logic [56:0] cord_data;
  logic        cord_done = 1'b0;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [5:0]  wr_row;
  logic [56:0] wr_data;
  logic        err;

  always #5 clk = ~clk;

  cordic_rotation_scheduler #(
    .LAT(2)
`ifdef SCHED_TIMEOUT_EN
    , .TMO(100)
`endif
  ) dut (
    .logicCLK(clk), .KEY0_N(rst_n), .req(req), .angle_in(angle_in),
    .ack(ack), .busy(busy), .cord_rst(cord_rst), .cord_angle(cord_angle),
    .cord_idx(cord_idx), .cord_data(cord_data), .cord_done(cord_done),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_data(wr_data), .err(err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Recognisable row pattern so row/index alignment is visible in wr_data.
  function automatic logic [56:0] fdat(input logic [9:0] idx, input logic [12:0] ang);
    return {7'h55, ang, 27'h5A5A5A5, idx};
  endfunction

  // Engine model: two-stage data pipeline, done 5 cycles after cord_rst,
  // optional hold-low and optional drop just before cord_idx reaches drop_k.
  logic [56:0] d1, d2;
  int eng_cnt = 0;
  int drop_k = 0;
  logic eng_hold = 1'b0;
  assign cord_data = d2;

  always @(posedge clk) begin
    d1 <= fdat(cord_idx, cord_angle);
    d2 <= d1;
    if (cord_rst) begin
      cord_done <= 1'b0;
      eng_cnt   <= 4;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1 && !eng_hold) cord_done <= 1'b1;
    end else if (drop_k > 0 && cord_done && cord_idx == 10'(drop_k - 1)) begin
      cord_done <= 1'b0;
    end
  end

  // Write / ack / err monitor.
  logic [2:0]  mon_sel = '0;
  logic [12:0] mon_angle = '0;
  int mon_row = 0, wr_cnt = 0, ack_cnt = 0, err_cnt = 0, ack_cyc = 0, err_cyc = 0;
  logic [1:0] last_ack = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wr_en) begin
          checks++;
          if (wr_sel !== mon_sel || wr_row !== 6'(mon_row) || wr_data !== fdat(10'(mon_row), mon_angle)) begin
            failures++;
            $display("FAIL write: got sel=%0d row=%0d data=%h, want sel=%0d row=%0d data=%h",
                     wr_sel, wr_row, wr_data, mon_sel, mon_row, fdat(10'(mon_row), mon_angle));
          end
          mon_row++;
          wr_cnt++;
        end
        if (ack != 2'b00) begin
          ack_cnt++;
          last_ack = ack;
          ack_cyc  = cyc;
        end
        if (err) begin
          err_cnt++;
          err_cyc = cyc;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic mon_arm(input logic [2:0] sel, input logic [12:0] ang);
    mon_sel = sel; mon_angle = ang; mon_row = 0;
    wr_cnt = 0; ack_cnt = 0; err_cnt = 0; last_ack = '0;
  endtask

  task automatic wait_grant(output bit ok, output int at);
    ok = 0; at = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cord_rst) begin ok = 1; at = cyc; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL grant_timeout: got no cord_rst, want cord_rst within 12 cycles");
    end
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [12:0] a0;
    logic [12:0] a1;
    logic [2:0]  sel;
    logic [12:0] ang;
    int          writes;
    logic [1:0]  ack;
    logic        err;
    int          drop;
  } vec_t;

  vec_t vecs [6];

  task automatic run_job(input int n, input vec_t v);
    bit ok; int at; bit idle;
    @(negedge clk);
    req = v.req; angle_in = {v.a1, v.a0}; drop_k = v.drop;
    wait_grant(ok, at);
    if (ok) begin
      req = 2'b00;
      mon_arm(v.sel, v.ang);
      chk($sformatf("v%0d_angle_at_grant", n), 64'(cord_angle), 64'(v.ang));
      idle = 0;
      for (int i = 1; i <= 200; i++) begin
        @(negedge clk);
        if (i == 12) angle_in = ~angle_in;
        if (i == 20) chk($sformatf("v%0d_angle_held", n), 64'(cord_angle), 64'(v.ang));
        if (!busy) begin idle = 1; break; end
      end
      chk($sformatf("v%0d_job_finished", n), 64'(idle), 64'd1);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_writes", n), 64'(wr_cnt), 64'(v.writes));
      chk($sformatf("v%0d_ack", n), 64'(last_ack), 64'(v.ack));
      chk($sformatf("v%0d_ack_count", n), 64'(ack_cnt), (v.ack != 2'b00) ? 64'd1 : 64'd0);
      chk($sformatf("v%0d_err_count", n), 64'(err_cnt), 64'(v.err));
    end
    drop_k = 0;
  endtask

  initial begin
    bit ok; int at; int rst_cyc; int prev_ack_cyc; int wc; bit hit;

    vecs[0] = '{2'b01, 13'h0123, 13'h1FFF, 3'd0, 13'h0123, 57, 2'b01, 1'b0, 0};
    vecs[1] = '{2'b11, 13'h0456, 13'h1ABC, 3'd1, 13'h1ABC, 57, 2'b10, 1'b0, 0};
    vecs[2] = '{2'b10, 13'h0111, 13'h0222, 3'd1, 13'h0222, 57, 2'b10, 1'b0, 0};
    vecs[3] = '{2'b11, 13'h0F0F, 13'h10F0, 3'd0, 13'h0F0F, 18, 2'b00, 1'b1, 20};
    vecs[4] = '{2'b11, 13'h0ACE, 13'h1BDF, 3'd0, 13'h0ACE, 57, 2'b01, 1'b0, 0};
    vecs[5] = '{2'b11, 13'h1357, 13'h0246, 3'd1, 13'h0246, 57, 2'b10, 1'b0, 0};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cord_rst", 64'(cord_rst), 64'd0);
    chk("rst_cord_angle", 64'(cord_angle), 64'd0);
    chk("rst_cord_idx", 64'(cord_idx), 64'd0);
    chk("rst_wr", 64'({wr_en, wr_sel, wr_row}), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven jobs (includes mid-stream abort and regrant).
    for (int n = 0; n < 6; n++) begin
      run_job(n, vecs[n]);
      $display("vector %0d req=%b sel=%0d writes=%0d ack=%b err=%0d", n, vecs[n].req, vecs[n].sel, wr_cnt, last_ack, err_cnt);
    end

    // Back-to-back: req=11 held, ptr at 0 -> 0,1,0,1 with one IDLE cycle between.
    @(negedge clk);
    req = 2'b11; angle_in = {13'h1555, 13'h0AAA};
    prev_ack_cyc = 0;
    for (int j = 0; j < 4; j++) begin
      wait_grant(ok, rst_cyc);
      if (!ok) break;
      mon_arm(3'(j % 2), (j % 2 == 1) ? 13'h1555 : 13'h0AAA);
      chk($sformatf("b2b%0d_angle", j), 64'(cord_angle), (j % 2 == 1) ? 64'h1555 : 64'h0AAA);
      if (j > 0) chk($sformatf("b2b%0d_gap", j), 64'(rst_cyc - prev_ack_cyc), 64'd2);
      hit = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (ack != 2'b00) begin hit = 1; break; end
      end
      prev_ack_cyc = cyc;
      chk($sformatf("b2b%0d_ack", j), 64'(ack), (j % 2 == 1) ? 64'h2 : 64'h1);
      if (j == 3) req = 2'b00;
      @(negedge clk);
      chk($sformatf("b2b%0d_writes", j), 64'(wr_cnt), 64'd57);
      $display("b2b job %0d sel=%0d ack_hit=%0d writes=%0d", j, j % 2, hit, wr_cnt);
    end

    // Async reset mid-stream, then requester 1 alone must be served.
    repeat (2) @(negedge clk);
    req = 2'b01; angle_in = {13'h1111, 13'h0321};
    wait_grant(ok, at);
    mon_arm(3'd0, 13'h0321);
    req = 2'b01;
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cord_idx == 10'd30) begin hit = 1; break; end
    end
    chk("rstmid_reached_k30", 64'(hit), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_angle_idx", 64'({cord_angle, cord_idx}), 64'd0);
    chk("rstmid_wr", 64'({wr_en, wr_sel, wr_row}), 64'd0);
    chk("rstmid_data", 64'(wr_data), 64'd0);
    chk("rstmid_pulses", 64'({ack, cord_rst, err}), 64'd0);
    wc = wr_cnt;
    repeat (3) @(negedge clk);
    req = 2'b10;
    rst_n = 1'b1;
    chk("rstmid_ack_count", 64'(ack_cnt), 64'd0);
    wait_grant(ok, at);
    chk("rstmid_no_writes", 64'(wr_cnt), 64'(wc));
    chk("rstmid_regrant_req1", 64'(cord_angle), 64'h1111);
    mon_arm(3'd1, 13'h1111);
    req = 2'b00;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    repeat (2) @(negedge clk);
    chk("rstmid_job_writes", 64'(wr_cnt), 64'd57);
    chk("rstmid_job_ack", 64'(last_ack), 64'h2);
    $display("reset-mid-stream: writes before reset=%0d, requester 1 job writes=%0d", wc, wr_cnt);

    // cord_done never arrives.
    eng_hold = 1'b1;
    @(negedge clk);
    req = 2'b01; angle_in = {13'h0000, 13'h0777};
    wait_grant(ok, rst_cyc);
    mon_arm(3'd0, 13'h0777);
    req = 2'b00;
`ifdef SCHED_TIMEOUT_EN
    hit = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (err) begin hit = 1; break; end
    end
    chk("tmo_err_seen", 64'(hit), 64'd1);
    chk("tmo_err_cycle", 64'(cyc - rst_cyc), 64'd101);
    chk("tmo_busy_low", 64'(busy), 64'd0);
    chk("tmo_no_writes", 64'(wr_cnt), 64'd0);
    chk("tmo_no_ack", 64'(ack_cnt), 64'd0);
    $display("timeout: err after %0d cycles from cord_rst", cyc - rst_cyc);
`else
    repeat (300) @(negedge clk);
    chk("hold_busy", 64'(busy), 64'd1);
    chk("hold_no_writes", 64'(wr_cnt), 64'd0);
    chk("hold_no_err", 64'(err_cnt), 64'd0);
    $display("hold: busy=%0d after 300 cycles without cord_done", busy);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
`endif
    eng_hold = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
